// File: rtl/control_contador_pkg.sv
// Shared definitions for the capture sequencer: state encoding, slot codes
// and small decode helpers used by the FSM.
package control_contador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SLOT1 = 3'd1,
        ST_SLOT2 = 3'd2,
        ST_SLOT3 = 3'd3,
        ST_DONE  = 3'd4
    } estado_e;

    localparam logic [1:0] SLOT_NONE = 2'b00;
    localparam logic [1:0] SLOT_1    = 2'b01;
    localparam logic [1:0] SLOT_2    = 2'b10;
    localparam logic [1:0] SLOT_3    = 2'b11;

    function automatic logic [1:0] slot_code(input estado_e s);
        logic [1:0] code;
        case (s)
            ST_SLOT1: code = SLOT_1;
            ST_SLOT2: code = SLOT_2;
            ST_SLOT3: code = SLOT_3;
            default:  code = SLOT_NONE;
        endcase
        return code;
    endfunction

    function automatic logic is_slot(input estado_e s);
        return (s == ST_SLOT1) || (s == ST_SLOT2) || (s == ST_SLOT3);
    endfunction

    // Slot that follows a completed capture; the last slot hands over to DONE.
    function automatic estado_e next_slot(input estado_e s);
        estado_e n;
        case (s)
            ST_SLOT1: n = ST_SLOT2;
            ST_SLOT2: n = ST_SLOT3;
            ST_SLOT3: n = ST_DONE;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/control_contador_if.sv
// Board-side bundle of the capture sequencer: raw controls in, slot code,
// strobe and status out, plus the FSM state for observation.
//
// Handshake: iniciar and cancelar are level-sampled requests with no ready
// path; captura is a one-cycle strobe that qualifies Contador_Control in the
// same cycle, and the consumer must load on it unconditionally.
interface control_contador_if;
    logic       iniciar;
    logic       cancelar;
    logic       boton;
    logic [1:0] Contador_Control;
    logic       captura;
    logic       ocupado;
    logic       listo;
    logic       error_to;
    logic [2:0] estado_dbg;

    modport master (
        output iniciar, cancelar, boton,
        input  Contador_Control, captura, ocupado, listo, error_to, estado_dbg
    );

    modport slave (
        input  iniciar, cancelar, boton,
        output Contador_Control, captura, ocupado, listo, error_to, estado_dbg
    );
endinterface

// File: rtl/control_contador_antirrebote.sv
// Button conditioning: 2-flop synchronizer, stability counter that flips the
// debounced level after DEB_CYCLES differing samples, and rising-edge pulse.
module antirrebote #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic boton,
    output logic pulso
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic          deb_prev_q, deb_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    // Any agreeing sample restarts the count, so only an unbroken run flips.
    always_comb begin
        sync1_d    = boton;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        cnt_d      = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = ~deb_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        pulso = deb_q & ~deb_prev_q;
    end

endmodule

// File: rtl/control_contador.sv
// Capture sequencer: started by iniciar, steps through three slots on
// debounced presses and strobes captura once per slot.
// Optional per-slot timeout enabled by defining CONTROL_TIMEOUT_EN.
module control_contador
    import control_contador_pkg::*;
#(
    parameter int DEB_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         reset,
    control_contador_if.slave bus
);

    logic       pulso;
    estado_e    state_q, state_d;
    logic       captura_q, captura_d;
    logic [1:0] contador_q, contador_d;
    logic       error_to_q, error_to_d;
    logic       timeout_hit;

    antirrebote #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_antirrebote (
        .clk   (clk),
        .reset (reset),
        .boton (bus.boton),
        .pulso (pulso)
    );

`ifdef CONTROL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        timeout_hit = is_slot(state_q) && (to_cnt_q == TO_MAX);
    end

    // Restart on every slot entry (including a slot advance) and on any press.
    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!is_slot(state_d) || (state_d != state_q) || pulso) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    always_comb begin
        timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            captura_q  <= 1'b0;
            contador_q <= SLOT_NONE;
            error_to_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            captura_q  <= captura_d;
            contador_q <= contador_d;
            error_to_q <= error_to_d;
        end
    end

    // A slot holds its code for the strobe cycle and advances one edge later;
    // a press landing on the strobe cycle is dropped.
    always_comb begin
        state_d    = state_q;
        captura_d  = 1'b0;
        error_to_d = 1'b0;
        if (bus.cancelar) begin
            state_d = ST_IDLE;
        end else if (timeout_hit) begin
            state_d    = ST_IDLE;
            error_to_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.iniciar) begin
                        state_d = ST_SLOT1;
                    end
                end
                ST_SLOT1, ST_SLOT2, ST_SLOT3: begin
                    if (captura_q) begin
                        state_d = next_slot(state_q);
                    end else if (pulso) begin
                        captura_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        contador_d = slot_code(state_d);
    end

    always_comb begin
        bus.Contador_Control = contador_q;
        bus.captura          = captura_q;
        bus.ocupado          = is_slot(state_q);
        bus.listo            = (state_q == ST_DONE);
        bus.error_to         = error_to_q;
        bus.estado_dbg       = state_q;
    end

endmodule

// File: tb/tb_control_contador.sv
// Self-checking bench for control_contador with DEB_CYCLES=4, TIMEOUT_CYCLES=50.
module tb_control_contador;
    localparam int DEB = 4;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic reset;
    control_contador_if bus ();

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    control_contador #(
        .DEB_CYCLES     (DEB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and safety limit
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.iniciar  = 1'b0;
        bus.cancelar = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_iniciar();
        @(negedge clk);
        bus.iniciar = 1'b1;
        @(negedge clk);
        bus.iniciar = 1'b0;
    endtask

    task automatic release_button();
        bus.boton = 1'b0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if (bus.Contador_Control !== 2'b00 || bus.captura !== 1'b0 || bus.ocupado !== 1'b0 ||
            bus.listo !== 1'b0 || bus.error_to !== 1'b0) begin
            n_err++;
            $display("FAIL %s: code=%b cap=%b ocu=%b listo=%b err=%b, expected 00 0 0 0 0",
                     name, bus.Contador_Control, bus.captura, bus.ocupado, bus.listo, bus.error_to);
        end
    endtask

    // Press, expect one strobe with code cur at DEB+2 edges, then code nxt.
    task automatic press_check(input logic [1:0] cur, input logic [1:0] nxt, input string name);
        int first;
        int strobes;
        logic [1:0] exp;
        first = -1;
        strobes = 0;
        exp_q.push_back(cur);
        @(negedge clk);
        bus.boton = 1'b1;
        for (int k = 0; k < DEB + 8; k++) begin
            @(negedge clk);
            if (bus.captura === 1'b1) begin
                strobes++;
                if (first < 0) begin
                    first = k;
                    exp = exp_q.pop_front();
                    n_cmp++;
                    if (bus.Contador_Control !== exp) begin
                        n_err++;
                        $display("FAIL %s strobe code: got %b expected %b", name, bus.Contador_Control, exp);
                    end
                end
            end
            if (k == DEB + 3) begin
                n_cmp++;
                if (bus.Contador_Control !== nxt) begin
                    n_err++;
                    $display("FAIL %s advance code: got %b expected %b", name, bus.Contador_Control, nxt);
                end
            end
        end
        if (first < 0) exp = exp_q.pop_front();
        n_cmp++;
        if (first !== DEB + 2) begin
            n_err++;
            $display("FAIL %s strobe latency: got %0d expected %0d", name, first, DEB + 2);
        end
        n_cmp++;
        if (strobes !== 1) begin
            n_err++;
            $display("FAIL %s strobe count: got %0d expected 1", name, strobes);
        end
        release_button();
    endtask

    // Scenario tasks
    task automatic test_reset();
        int strobes;
        bus.boton = 1'b1;
        bus.iniciar = 1'b0;
        bus.cancelar = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        n_cmp++;
        if (bus.estado_dbg !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", bus.estado_dbg);
        end
        reset = 1'b0;
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.captura === 1'b1 || bus.Contador_Control !== 2'b00) strobes++;
        end
        n_cmp++;
        if (strobes !== 0) begin
            n_err++;
            $display("FAIL held_button_idle: got %0d active cycles expected 0", strobes);
        end
        release_button();
    endtask

    task automatic test_sequence();
        do_reset();
        pulse_iniciar();
        n_cmp++;
        if (bus.Contador_Control !== 2'b01 || bus.ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL start: code=%b ocu=%b expected 01 1", bus.Contador_Control, bus.ocupado);
        end
        press_check(2'b01, 2'b10, "slot1");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        press_check(2'b10, 2'b11, "slot2");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        press_check(2'b11, 2'b00, "slot3");
        n_cmp++;
        if (bus.listo !== 1'b1 || bus.ocupado !== 1'b0 || bus.Contador_Control !== 2'b00) begin
            n_err++;
            $display("FAIL done: listo=%b ocu=%b code=%b expected 1 0 00",
                     bus.listo, bus.ocupado, bus.Contador_Control);
        end
        pulse_iniciar();
        n_cmp++;
        if (bus.listo !== 1'b0 || bus.Contador_Control !== 2'b01) begin
            n_err++;
            $display("FAIL restart_from_done: listo=%b code=%b expected 0 01", bus.listo, bus.Contador_Control);
        end
    endtask

    task automatic test_glitch();
        int strobes;
        int len;
        do_reset();
        pulse_iniciar();
        len = $urandom_range(1, DEB - 1);
        @(negedge clk);
        bus.boton = 1'b1;
        repeat (len) @(negedge clk);
        bus.boton = 1'b0;
        strobes = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.captura === 1'b1) strobes++;
        end
        n_cmp++;
        if (strobes !== 0) begin
            n_err++;
            $display("FAIL glitch_strobe (len %0d): got %0d expected 0", len, strobes);
        end
        n_cmp++;
        if (bus.Contador_Control !== 2'b01) begin
            n_err++;
            $display("FAIL glitch_code: got %b expected 01", bus.Contador_Control);
        end
    endtask

    task automatic test_cancel();
        int strobes;
        do_reset();
        pulse_iniciar();
        press_check(2'b01, 2'b10, "cancel_pre");
        strobes = 0;
        @(negedge clk);
        bus.boton = 1'b1;
        for (int k = 0; k < DEB + 8; k++) begin
            @(negedge clk);
            if (bus.captura === 1'b1) strobes++;
            if (k == DEB + 1) bus.cancelar = 1'b1;
            if (k == DEB + 2) begin
                bus.cancelar = 1'b0;
                n_cmp++;
                if (bus.captura !== 1'b0 || bus.Contador_Control !== 2'b00 || bus.ocupado !== 1'b0) begin
                    n_err++;
                    $display("FAIL cancel_vs_pulso: cap=%b code=%b ocu=%b expected 0 00 0",
                             bus.captura, bus.Contador_Control, bus.ocupado);
                end
            end
        end
        n_cmp++;
        if (strobes !== 0) begin
            n_err++;
            $display("FAIL cancel_no_strobe: got %0d expected 0", strobes);
        end
        release_button();
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp;
        do_reset();
        pulse_iniciar();
        press_check(2'b01, 2'b10, "mid_s1");
        press_check(2'b10, 2'b11, "mid_s2");
        exp_q.push_back(2'b11);
        @(negedge clk);
        bus.boton = 1'b1;
        for (int k = 0; k < DEB + 4; k++) begin
            @(negedge clk);
            if (k == DEB + 2) begin
                exp = exp_q.pop_front();
                n_cmp++;
                if (bus.captura !== 1'b1 || bus.Contador_Control !== exp) begin
                    n_err++;
                    $display("FAIL slot3_strobe: cap=%b code=%b expected 1 %b",
                             bus.captura, bus.Contador_Control, exp);
                end
                reset = 1'b1;
            end
            if (k == DEB + 3) begin
                reset = 1'b0;
                check_idle_outputs("reset_mid");
            end
        end
        release_button();
        check_idle_outputs("reset_mid_idle");
        pulse_iniciar();
        n_cmp++;
        if (bus.Contador_Control !== 2'b01 || bus.ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL restart_after_reset: code=%b ocu=%b expected 01 1",
                     bus.Contador_Control, bus.ocupado);
        end
    endtask

    task automatic test_timeout();
        int first;
        int pulses;
        do_reset();
        pulse_iniciar();
        first = -1;
        pulses = 0;
`ifdef CONTROL_TIMEOUT_EN
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge clk);
            if (bus.error_to === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        n_cmp++;
        if (first !== TO || pulses !== 1) begin
            n_err++;
            $display("FAIL timeout_pulse: first=%0d count=%0d expected %0d 1", first, pulses, TO);
        end
        n_cmp++;
        if (bus.Contador_Control !== 2'b00 || bus.ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_code: code=%b ocu=%b expected 00 0", bus.Contador_Control, bus.ocupado);
        end
`else
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (bus.error_to === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL no_timeout_pulse: got %0d expected 0", pulses);
        end
        n_cmp++;
        if (bus.Contador_Control !== 2'b01 || bus.ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL no_timeout_code: code=%b ocu=%b expected 01 1", bus.Contador_Control, bus.ocupado);
        end
`endif
    endtask

    // Sequence and final report
    initial begin
        bus.iniciar  = 1'b0;
        bus.cancelar = 1'b0;
        bus.boton    = 1'b0;
        reset        = 1'b1;
        test_reset();
        test_sequence();
        test_glitch();
        test_cancel();
        test_reset_mid();
        test_timeout();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
